mo_mul_arbiter: RTL and testbench

Round-robin arbiter and scheduler that shares one pipelined `mo_mul` Montgomery multiplier between `N_REQ` requesters, such as NTT butterfly lanes and the pointwise-multiply unit. It accepts at most one operand pair per cycle and drives the multiplier from registered operands. A tag pipeline matched to the multiplier latency carries each operation's requester ID, and each result is returned to the requester that issued it. A `drain` input blocks new grants and an `idle` output reports when nothing is in flight, so the block can be used for NTT layer-boundary sequencing.

---
 rtl/mo_mul_arbiter.sv | 140 ++++++++++++++
 tb/tb_mo_mul_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mo_mul_arbiter.sv
// rtl/mo_mul_arbiter.sv - round-robin scheduler sharing one pipelined mo_mul multiplier
// Grants one operand pair per cycle and routes each result back via a latency-matched tag pipe.
package ntt_pkg;
  localparam int DATA_WIDTH = 16;
endpackage

module mo_mul_arbiter
  import ntt_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int MUL_LATENCY = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                drain,
  input  logic [N_REQ-1:0]                    req_valid,
  output logic [N_REQ-1:0]                    req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0]         req_a,
  input  logic [N_REQ*DATA_WIDTH-1:0]         req_b,
  output logic [N_REQ-1:0]                    rsp_valid,
  output logic [DATA_WIDTH-1:0]               rsp_data,
  output logic [DATA_WIDTH-1:0]               mul_a,
  output logic [DATA_WIDTH-1:0]               mul_b,
  input  logic [DATA_WIDTH-1:0]               mul_result,
  output logic [$clog2(MUL_LATENCY+3)-1:0]    inflight,
  output logic                                idle
);

  localparam int ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MUL_LATENCY + 3);

  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic                  grant_found;
  logic [ID_W-1:0]       grant_id;
  logic                  hs;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;
  logic [DATA_WIDTH-1:0] mul_a_q, mul_b_q;
  logic [MUL_LATENCY:0]  tag_vld_q;
  logic [ID_W-1:0]       tag_id_q [MUL_LATENCY+1];
  logic [N_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]      inflight_q, inflight_d;

  // Search upward from ptr with wrap; the first asserted requester wins.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    grant_found = 1'b0;
    grant_id    = '0;
    sum         = '0;
    idx         = '0;
    for (int off = 0; off < N_REQ; off++) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(off);
      if (sum >= (ID_W+1)'(N_REQ)) begin
        sum = sum - (ID_W+1)'(N_REQ);
      end
      idx = sum[ID_W-1:0];
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
    if (rst || drain) begin
      grant_found = 1'b0;
    end
  end

  assign hs = grant_found;

  always_comb begin
    req_ready = '0;
    if (grant_found) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign sel_a = req_a[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign sel_b = req_b[grant_id*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    ptr_d = ptr_q;
    if (hs) begin
      ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Only the tag valid carries meaning through reset; stale ids are never consumed.
  always_ff @(posedge clk) begin
    tag_id_q[0] <= grant_id;
    for (int s = 1; s <= MUL_LATENCY; s++) begin
      tag_id_q[s] <= tag_id_q[s-1];
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_vld_q[MUL_LATENCY]) begin
      rsp_valid_d[tag_id_q[MUL_LATENCY]] = 1'b1;
      rsp_data_d                         = mul_result;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({hs, |rsp_valid_q})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_vld_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      inflight_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mul_a_q     <= hs ? sel_a : '0;
      mul_b_q     <= hs ? sel_b : '0;
      tag_vld_q   <= {tag_vld_q[MUL_LATENCY-1:0], hs};
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      inflight_q  <= inflight_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign inflight  = inflight_q;
  assign idle      = (inflight_q == '0);

endmodule

// File: tb/tb_mo_mul_arbiter.sv
// tb/tb_mo_mul_arbiter.sv - scoreboard bench for mo_mul_arbiter with an adder stand-in multiplier
module tb_mo_mul_arbiter;
  localparam int N  = 4;
  localparam int L  = 6;
  localparam int W  = ntt_pkg::DATA_WIDTH;
  localparam int CW = $clog2(L + 3);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           drain = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [W-1:0]   rsp_data, mul_a, mul_b, mul_result;
  logic [CW-1:0]  inflight;
  logic           idle;
  logic [W-1:0]   mul_pipe [L];

  mo_mul_arbiter #(.N_REQ(N), .MUL_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .drain(drain),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .inflight(inflight), .idle(idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mul_pipe[0] <= mul_a + mul_b;
    for (int k = 1; k < L; k++) mul_pipe[k] <= mul_pipe[k-1];
  end
  assign mul_result = mul_pipe[L-1];

  typedef struct { int id; logic [W-1:0] res; int due; } op_t;
  op_t          ops[$];
  int           cyc = 0;
  int           m_ptr = 0;
  logic [W-1:0] m_mul_a = '0, m_mul_b = '0, m_rsp_data = '0;
  bit           live = 1'b0;
  int           n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int model_grant();
    if (rst || drain) return -1;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  // Model: a list of accepted operations, each due on rsp exactly L+2 cycles after its grant.
  initial begin
    int g;
    op_t t;
    logic [W-1:0] a, b;
    forever begin
      @(posedge clk);
      if (rst) begin
        ops.delete();
        m_ptr = 0; m_mul_a = '0; m_mul_b = '0; m_rsp_data = '0;
        cyc = 0; live = 1'b1;
      end else begin
        if (ops.size() > 0 && ops[0].due == cyc) begin
          m_rsp_data = ops[0].res;
          void'(ops.pop_front());
        end
        g = model_grant();
        if (g >= 0) begin
          a = req_a[g*W +: W];
          b = req_b[g*W +: W];
          t.id = g; t.res = a + b; t.due = cyc + L + 2;
          ops.push_back(t);
          m_ptr = (g + 1) % N;
          m_mul_a = a; m_mul_b = b;
        end else begin
          m_mul_a = '0; m_mul_b = '0;
        end
        cyc++;
      end
    end
  end

  initial begin
    int g;
    logic [N-1:0] e_rdy, e_rv;
    logic [W-1:0] e_rd;
    forever begin
      @(negedge clk);
      if (live) begin
        g = model_grant();
        e_rdy = '0;
        if (g >= 0) e_rdy[g] = 1'b1;
        e_rv = '0;
        e_rd = m_rsp_data;
        if (ops.size() > 0 && ops[0].due == cyc) begin
          e_rv[ops[0].id] = 1'b1;
          e_rd = ops[0].res;
        end
        chk("req_ready", req_ready, e_rdy);
        chk("mul_a", mul_a, m_mul_a);
        chk("mul_b", mul_b, m_mul_b);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_data", rsp_data, e_rd);
        chk("inflight", inflight, ops.size());
        chk("idle", idle, ops.size() == 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    for (int k = 0; k < 300 && cyc != c; k++) step();
    chk("goto", cyc, c);
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  initial begin
    int gl, g0;
    // Reset: ready must stay low while rst is high even with requests pending.
    step();
    req_valid = 4'b1111;
    @(negedge clk); chk("rst_ready", req_ready, 4'b0000);
    step();
    rst = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_idle", idle, 1);

    // Single request from requester 2.
    goto(10);
    req_valid = 4'b0100; set_req(2, 5, 7);
    @(negedge clk); chk("t1_ready", req_ready, 4'b0100);
    step(); req_valid = '0;
    @(negedge clk);
    chk("t1_mul_a", mul_a, 5); chk("t1_mul_b", mul_b, 7); chk("t1_inflight", inflight, 1);
    goto(18);
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 4'b0100); chk("t1_rsp_data", rsp_data, 12);
    chk("t1_inflight18", inflight, 1);
    step();
    @(negedge clk); chk("t1_inflight19", inflight, 0); chk("t1_idle19", idle, 1);

    // Full contention straight out of reset.
    rst = 1'b1; req_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_req(i, i, 100);
    step(); rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); chk("t2_grant", req_ready, 4'b0001 << (k % 4));
      step();
    end
    req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t2_rsp_valid", rsp_valid, 4'b0001 << (k % 4));
      chk("t2_rsp_data", rsp_data, 100 + (k % 4));
      if (k == 0) chk("t2_inflight_max", inflight, 8);
      step();
    end

    // Pointer fairness: move ptr to 2, then contend between 0 and 3.
    goto(17);
    req_valid = 4'b0010;
    step();
    req_valid = 4'b1001;
    @(negedge clk); chk("t3_g0", req_ready, 4'b1000); step();
    @(negedge clk); chk("t3_g1", req_ready, 4'b0001); step();
    @(negedge clk); chk("t3_g2", req_ready, 4'b1000); step();
    req_valid = '0;

    // Drain after three back-to-back operations.
    goto(cyc + 10);
    for (int i = 0; i < N; i++) set_req(i, i + 10, 1);
    req_valid = 4'b0111;
    @(negedge clk); chk("t4_g0", req_ready, 4'b0001); step();
    @(negedge clk); chk("t4_g1", req_ready, 4'b0010); step();
    @(negedge clk); chk("t4_g2", req_ready, 4'b0100);
    gl = cyc;
    step();
    drain = 1'b1; req_valid = 4'b1111;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("t4_drain_ready", req_ready, 4'b0000);
      if (k == 8) begin
        chk("t4_last_rsp", rsp_valid, 4'b0100);
        chk("t4_last_data", rsp_data, 13);
        chk("t4_idle_low", idle, 0);
      end
      if (k == 9) chk("t4_idle_high", idle, 1);
      step();
    end
    chk("t4_cycle", cyc, gl + 13);
    drain = 1'b0;
    @(negedge clk); chk("t4_resume", req_ready, 4'b1000);
    step(); req_valid = '0;

    // Reset while four operations are in flight.
    goto(cyc + 12);
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) step();
    req_valid = '0;
    step(); step();
    rst = 1'b1; req_valid = 4'b1010;
    @(negedge clk); chk("t5_rst_ready", req_ready, 4'b0000);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("t5_inflight", inflight, 0); chk("t5_idle", idle, 1);
    chk("t5_first_grant", req_ready, 4'b0010);
    step(); req_valid = '0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk); chk("t5_no_rsp", rsp_valid, 4'b0000);
      step();
    end
    @(negedge clk); chk("t5_new_rsp", rsp_valid, 4'b0010);

    // Back-to-back grants to a single requester.
    goto(14);
    req_valid = 4'b0010;
    g0 = cyc;
    for (int k = 1; k <= 5; k++) begin
      set_req(1, k, 0);
      @(negedge clk); chk("t6_grant", req_ready, 4'b0010);
      step();
    end
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      goto(g0 + 8 + k);
      @(negedge clk);
      chk("t6_rsp_valid", rsp_valid, 4'b0010);
      chk("t6_rsp_data", rsp_data, k + 1);
    end
    step();
    @(negedge clk); chk("t6_rsp_end", rsp_valid, 4'b0000);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_cmp++; n_fail++;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
